// File: rtl/ws2812_pattern_gen.sv
// Pattern source for a WS2812 driver: once per frame period, issues one write
// strobe per LED carrying its index and a colour from the selected pattern.
module ws2812_pattern_gen #(
    parameter int unsigned NUM_LEDS    = 4,
    parameter int unsigned FRAME_TICKS = 1000000,
    parameter int unsigned WHEEL_STEP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] base_colour,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        frame_done,
    output logic [7:0]  frame
);

    localparam int unsigned TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);
    localparam logic [7:0] LED_STEP = 8'(256 / NUM_LEDS);
    localparam logic [7:0] WSTEP    = 8'(WHEEL_STEP);

    typedef enum logic [1:0] {S_WAIT, S_WRITE, S_DONE} state_t;

    state_t             state, state_d;
    logic [TICK_W-1:0]  tick;
    logic [7:0]         idx, idx_d;
    logic [7:0]         chase_idx, chase_idx_d;
    logic [7:0]         wheel_base, wheel_base_d;
    logic [7:0]         p_acc, p_acc_d;
    logic [1:0]         mode_q, mode_d;
    logic [23:0]        colour_q, colour_d;
    logic [23:0]        rgb_d;
    logic [7:0]         led_d, frame_d;
    logic               write_d, frame_done_d;

    function automatic logic [23:0] wheel(input logic [7:0] p);
        logic [7:0] q;
        logic [7:0] t;
        if (p < 8'd85) begin
            t = 8'(10'(p) * 10'd3);
            return {8'd255 - t, t, 8'd0};
        end else if (p < 8'd170) begin
            q = p - 8'd85;
            t = 8'(10'(q) * 10'd3);
            return {8'd0, 8'd255 - t, t};
        end else begin
            q = p - 8'd170;
            t = 8'(10'(q) * 10'd3);
            return {t, 8'd0, 8'd255 - t};
        end
    endfunction

    function automatic logic [23:0] colour(input logic [1:0] m, input logic [23:0] base,
                                           input logic [7:0] i, input logic [7:0] chase,
                                           input logic [7:0] p);
        case (m)
            2'd0:    return base;
            2'd1:    return (i == chase) ? base : 24'd0;
            2'd2:    return wheel(p);
            default: return 24'd0;
        endcase
    endfunction

    // Free-running frame tick, independent of enable and state
    always_ff @(posedge clk) begin
        if (reset || tick == LAST_TICK) tick <= '0;
        else                            tick <= tick + TICK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_WAIT;
            idx        <= '0;
            chase_idx  <= '0;
            wheel_base <= '0;
            p_acc      <= '0;
            mode_q     <= '0;
            colour_q   <= '0;
            rgb_data   <= '0;
            led_num    <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
            frame      <= '0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            chase_idx  <= chase_idx_d;
            wheel_base <= wheel_base_d;
            p_acc      <= p_acc_d;
            mode_q     <= mode_d;
            colour_q   <= colour_d;
            rgb_data   <= rgb_d;
            led_num    <= led_d;
            write      <= write_d;
            frame_done <= frame_done_d;
            frame      <= frame_d;
        end
    end

    // Next state and next registered outputs; LED 0 is emitted on the start edge
    always_comb begin
        state_d      = state;
        idx_d        = idx;
        chase_idx_d  = chase_idx;
        wheel_base_d = wheel_base;
        p_acc_d      = p_acc;
        mode_d       = mode_q;
        colour_d     = colour_q;
        rgb_d        = rgb_data;
        led_d        = led_num;
        write_d      = 1'b0;
        frame_done_d = 1'b0;
        frame_d      = frame;
        case (state)
            S_WAIT: begin
                if (tick == LAST_TICK && enable) begin
                    mode_d   = mode;
                    colour_d = base_colour;
                    write_d  = 1'b1;
                    led_d    = 8'd0;
                    rgb_d    = colour(mode, base_colour, 8'd0, chase_idx, wheel_base);
                    idx_d    = 8'd1;
                    p_acc_d  = wheel_base + LED_STEP;
                    state_d  = (NUM_LEDS == 1) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                write_d = 1'b1;
                led_d   = idx;
                rgb_d   = colour(mode_q, colour_q, idx, chase_idx, p_acc);
                idx_d   = idx + 8'd1;
                p_acc_d = p_acc + LED_STEP;
                if (idx == LAST_IDX) state_d = S_DONE;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                frame_d      = frame + 8'd1;
                wheel_base_d = wheel_base + WSTEP;
                chase_idx_d  = (chase_idx == LAST_IDX) ? 8'd0 : chase_idx + 8'd1;
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// Directed bench for ws2812_pattern_gen with NUM_LEDS=4, FRAME_TICKS=16, WHEEL_STEP=8.
module tb_ws2812_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] base_colour = 24'h000010;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;
    logic        frame_done;
    logic [7:0]  frame;

    int checks = 0;
    int errors = 0;

    logic [23:0] cap_rgb [4];
    logic [7:0]  cap_led [4];
    logic        cap_w   [4];
    logic        cap_done_w, cap_done_fd;
    logic [7:0]  cap_frame;

    ws2812_pattern_gen #(.NUM_LEDS(4), .FRAME_TICKS(16), .WHEEL_STEP(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .base_colour(base_colour), .rgb_data(rgb_data), .led_num(led_num),
        .write(write), .frame_done(frame_done), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts edges until write is seen high; ok=0 when the budget expires
    task automatic wait_write(input int max, output int n, output bit ok);
        n = 0;
        while (write !== 1'b1 && n < max) begin
            step();
            n++;
        end
        ok = (write === 1'b1);
    endtask

    // Records the four write cycles and the following done cycle
    task automatic capture_burst();
        for (int i = 0; i < 4; i++) begin
            cap_w[i]   = write;
            cap_led[i] = led_num;
            cap_rgb[i] = rgb_data;
            step();
        end
        cap_done_w  = write;
        cap_done_fd = frame_done;
        cap_frame   = frame;
    endtask

    task automatic check_wait(input string name, input int got, input bit ok, input int exp);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL %s: waited %0d cycles ok=%0b, expected %0d", name, got, ok, exp);
        end
    endtask

    task automatic test_reset();
        int n; bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rgb_data, led_num, write, frame_done, frame} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rgb=%h led=%0d w=%b fd=%b frame=%0d, expected all 0",
                     rgb_data, led_num, write, frame_done, frame);
        end
        reset = 1'b0;
        wait_write(40, n, ok);
        check_wait("reset_first_write", n, ok, 16);
    endtask

    task automatic test_solid();
        int n; bit ok;
        capture_burst();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_w[i] !== 1'b1 || cap_led[i] !== 8'(i) || cap_rgb[i] !== 24'h000010) begin
                errors++;
                $display("FAIL solid_write%0d: got w=%b led=%0d rgb=%h, expected 1 %0d 000010",
                         i, cap_w[i], cap_led[i], cap_rgb[i], i);
            end
        end
        checks++;
        if (cap_done_w !== 1'b0 || cap_done_fd !== 1'b1 || cap_frame !== 8'd1) begin
            errors++;
            $display("FAIL solid_done: got w=%b fd=%b frame=%0d, expected 0 1 1",
                     cap_done_w, cap_done_fd, cap_frame);
        end
        wait_write(40, n, ok);
        check_wait("solid_period", n, ok, 12);
    endtask

    task automatic test_chase();
        int n; bit ok;
        logic [23:0] exp;
        mode = 2'd1;
        base_colour = 24'hFF0000;
        do_reset();
        wait_write(40, n, ok);
        check_wait("chase_first_write", n, ok, 16);
        for (int f = 0; f < 5; f++) begin
            capture_burst();
            for (int i = 0; i < 4; i++) begin
                exp = (i == f % 4) ? 24'hFF0000 : 24'h000000;
                checks++;
                if (cap_w[i] !== 1'b1 || cap_led[i] !== 8'(i) || cap_rgb[i] !== exp) begin
                    errors++;
                    $display("FAIL chase_f%0d_led%0d: got w=%b led=%0d rgb=%h, expected rgb=%h",
                             f, i, cap_w[i], cap_led[i], cap_rgb[i], exp);
                end
            end
            checks++;
            if (cap_done_fd !== 1'b1 || cap_frame !== 8'(f + 1)) begin
                errors++;
                $display("FAIL chase_done_f%0d: got fd=%b frame=%0d, expected 1 %0d",
                         f, cap_done_fd, cap_frame, f + 1);
            end
            wait_write(40, n, ok);
            check_wait("chase_period", n, ok, 12);
        end
    endtask

    task automatic test_wheel();
        int n; bit ok;
        logic [23:0] exp0 [4];
        logic [23:0] exp1 [4];
        exp0 = '{24'hFF0000, 24'h3FC000, 24'h007E81, 24'h4200BD};
        exp1 = '{24'hE71800, 24'h27D800, 24'h006699, 24'h5A00A5};
        mode = 2'd2;
        do_reset();
        wait_write(40, n, ok);
        check_wait("wheel_first_write", n, ok, 16);
        capture_burst();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_rgb[i] !== exp0[i]) begin
                errors++;
                $display("FAIL wheel_f0_led%0d: got %h, expected %h", i, cap_rgb[i], exp0[i]);
            end
        end
        wait_write(40, n, ok);
        check_wait("wheel_period", n, ok, 12);
        capture_burst();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_rgb[i] !== exp1[i]) begin
                errors++;
                $display("FAIL wheel_f1_led%0d: got %h, expected %h", i, cap_rgb[i], exp1[i]);
            end
        end
    endtask

    task automatic test_disable();
        int n; bit ok;
        int stray_w, stray_fd, frame_bad;
        stray_w = 0; stray_fd = 0; frame_bad = 0;
        enable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (write === 1'b1)      stray_w++;
            if (frame_done === 1'b1) stray_fd++;
            if (frame !== 8'd2)      frame_bad++;
        end
        checks++;
        if (stray_w != 0 || stray_fd != 0 || frame_bad != 0) begin
            errors++;
            $display("FAIL disable_idle: got writes=%0d frame_dones=%0d frame_changes=%0d, expected 0 0 0",
                     stray_w, stray_fd, frame_bad);
        end
        enable = 1'b1;
        wait_write(40, n, ok);
        check_wait("disable_realign", n, ok, 4);
        capture_burst();
        checks++;
        if (cap_done_fd !== 1'b1 || cap_frame !== 8'd3 || cap_rgb[0] !== 24'hCF3000) begin
            errors++;
            $display("FAIL disable_resume: got fd=%b frame=%0d rgb0=%h, expected 1 3 cf3000",
                     cap_done_fd, cap_frame, cap_rgb[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        mode = 2'd0;
        base_colour = 24'h000010;
        wait_write(40, n, ok);
        check_wait("mid_pre_burst", n, ok, 12);
        step();
        reset = 1'b1;
        step();
        checks++;
        if (write !== 1'b0 || frame_done !== 1'b0 || frame !== 8'd0 || led_num !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_burst: got w=%b fd=%b frame=%0d led=%0d, expected 0 0 0 0",
                     write, frame_done, frame, led_num);
        end
        step();
        step();
        reset = 1'b0;
        wait_write(40, n, ok);
        check_wait("reset_mid_restart", n, ok, 16);
        checks++;
        if (led_num !== 8'd0 || rgb_data !== 24'h000010) begin
            errors++;
            $display("FAIL reset_mid_led0: got led=%0d rgb=%h, expected 0 000010", led_num, rgb_data);
        end
        capture_burst();
        checks++;
        if (cap_frame !== 8'd1 || cap_led[3] !== 8'd3) begin
            errors++;
            $display("FAIL reset_mid_done: got frame=%0d last_led=%0d, expected 1 3", cap_frame, cap_led[3]);
        end
    endtask

    task automatic test_mode_change();
        int n; bit ok;
        wait_write(40, n, ok);
        check_wait("mode_change_burst", n, ok, 12);
        mode = 2'd3;
        base_colour = 24'hFFFFFF;
        capture_burst();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_rgb[i] !== 24'h000010) begin
                errors++;
                $display("FAIL mode_change_hold_led%0d: got %h, expected 000010", i, cap_rgb[i]);
            end
        end
        wait_write(40, n, ok);
        check_wait("mode_off_burst", n, ok, 12);
        capture_burst();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_w[i] !== 1'b1 || cap_led[i] !== 8'(i) || cap_rgb[i] !== 24'h0) begin
                errors++;
                $display("FAIL mode_off_led%0d: got w=%b led=%0d rgb=%h, expected 1 %0d 000000",
                         i, cap_w[i], cap_led[i], cap_rgb[i], i);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int n; bit ok;
        int miss_fd, bad_frame, timeouts;
        miss_fd = 0; bad_frame = 0; timeouts = 0;
        mode = 2'd0;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            wait_write(40, n, ok);
            if (!ok) timeouts++;
            capture_burst();
            if (cap_done_fd !== 1'b1)      miss_fd++;
            if (cap_frame !== 8'(k + 1))   bad_frame++;
        end
        checks++;
        if (timeouts != 0 || miss_fd != 0 || bad_frame != 0) begin
            errors++;
            $display("FAIL frame_run: got timeouts=%0d missing_done=%0d bad_frame=%0d, expected 0 0 0",
                     timeouts, miss_fd, bad_frame);
        end
        checks++;
        if (cap_frame !== 8'd0 || cap_done_fd !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap: got frame=%0d fd=%b, expected 0 1", cap_frame, cap_done_fd);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_solid();
        test_chase();
        test_wheel();
        test_disable();
        test_reset_mid();
        test_mode_change();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
